// File: rtl/dram_arbiter_pkg.sv
// rtl/dram_arbiter_pkg.sv - shared constants and types for the unified memory bus arbiter
// Provides XLEN (default 32) when the build does not define it.
`ifndef XLEN
`define XLEN 32
`endif

package dram_arbiter_pkg;

  // Source IDs, also the 1-bit entries held in the response-order FIFO
  localparam logic SRC_IBUS = 1'b0;
  localparam logic SRC_DBUS = 1'b1;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  localparam logic [0:0] ARB_IDLE   = 1'b0;
  localparam logic [0:0] ARB_LOCKED = 1'b1;

  typedef struct packed {
    logic               wr;
    logic [1:0]         size;
    logic [`XLEN-1:0]   addr;
    logic [`XLEN/8-1:0] wstrb;
    logic [`XLEN-1:0]   wdata;
  } mem_cmd_t;

endpackage

// File: rtl/dram_arb_id_fifo.sv
// rtl/dram_arb_id_fifo.sv - in-order source-ID FIFO for outstanding unified bus transactions
// Push is ignored when full, pop is ignored when empty; pointers wrap modulo DEPTH.
module dram_arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push,
  input  logic             push_id,
  input  logic             pop,
  output logic             head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             ids [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = ids[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between push and pop
  always_ff @(posedge clk) begin
    if (do_push) ids[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - shares one sram-like memory bus between ibus and dbus with in-order response routing
// DRAM_ARB_RR_EN selects round-robin arbitration; undefined gives fixed dbus-over-ibus priority.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               ibus_req,
  input  logic [`XLEN-1:0]   ibus_addr,
  output logic               ibus_addr_ok,
  output logic               ibus_data_ok,
  output logic [`XLEN-1:0]   ibus_rdata,
  input  logic               dbus_req,
  input  logic               dbus_wr,
  input  logic [1:0]         dbus_size,
  input  logic [`XLEN-1:0]   dbus_addr,
  input  logic [`XLEN/8-1:0] dbus_wstrb,
  input  logic [`XLEN-1:0]   dbus_wdata,
  output logic               dbus_addr_ok,
  output logic               dbus_data_ok,
  output logic [`XLEN-1:0]   dbus_rdata,
  output logic               mem_req,
  output logic               mem_wr,
  output logic [1:0]         mem_size,
  output logic [`XLEN-1:0]   mem_addr,
  output logic [`XLEN/8-1:0] mem_wstrb,
  output logic [`XLEN-1:0]   mem_wdata,
  input  logic               mem_addr_ok,
  input  logic               mem_data_ok,
  input  logic [`XLEN-1:0]   mem_rdata,
  output logic               arb_err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [0:0]       state;
  logic             lock_src;
  logic             grant;
  logic             src_req;
  logic             accept;
  logic             resp_valid;
  logic             full;
  logic             fifo_empty;
  logic             fifo_head;
  logic [CNT_W-1:0] fifo_count;
  mem_cmd_t         icmd;
  mem_cmd_t         dcmd;
  mem_cmd_t         cmd;

`ifdef DRAM_ARB_RR_EN
  logic last_grant;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)      last_grant <= SRC_IBUS;
    else if (accept) last_grant <= grant;
  end
`endif

  always_comb begin
    grant = dbus_req ? SRC_DBUS : SRC_IBUS;
`ifdef DRAM_ARB_RR_EN
    if (ibus_req && dbus_req) grant = ~last_grant;
`endif
    // A stalled request keeps the bus until accepted, whatever the priority
    if (state == ARB_LOCKED) grant = lock_src;
  end

  assign src_req = (state == ARB_LOCKED) ? (lock_src ? dbus_req : ibus_req)
                                         : (ibus_req | dbus_req);

  // Full blocks issue even when a pop lands the same cycle, keeping data_ok off this path
  assign mem_req      = src_req & ~full & rst_b;
  assign accept       = mem_req & mem_addr_ok;
  assign ibus_addr_ok = accept & (grant == SRC_IBUS);
  assign dbus_addr_ok = accept & (grant == SRC_DBUS);

  assign icmd = '{wr: 1'b0, size: MEM_SIZE_W, addr: ibus_addr, wstrb: '0, wdata: '0};
  assign dcmd = '{wr: dbus_wr, size: dbus_size, addr: dbus_addr, wstrb: dbus_wstrb,
                  wdata: dbus_wdata};
  assign cmd  = (grant == SRC_DBUS) ? dcmd : icmd;

  assign mem_wr    = cmd.wr;
  assign mem_size  = cmd.size;
  assign mem_addr  = cmd.addr;
  assign mem_wstrb = cmd.wstrb;
  assign mem_wdata = cmd.wdata;

  assign resp_valid   = mem_data_ok & ~fifo_empty;
  assign ibus_data_ok = resp_valid & (fifo_head == SRC_IBUS);
  assign dbus_data_ok = resp_valid & (fifo_head == SRC_DBUS);
  assign ibus_rdata   = mem_rdata;
  assign dbus_rdata   = mem_rdata;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= ARB_IDLE;
      lock_src <= SRC_IBUS;
      arb_err  <= 1'b0;
    end else begin
      if (state == ARB_IDLE && mem_req && !mem_addr_ok) begin
        state    <= ARB_LOCKED;
        lock_src <= grant;
      end else if (state == ARB_LOCKED && mem_addr_ok) begin
        state <= ARB_IDLE;
      end
      if (mem_data_ok && fifo_count == '0) arb_err <= 1'b1;
    end
  end

  dram_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .push    (accept),
    .push_id (grant),
    .pop     (mem_data_ok),
    .head    (fifo_head),
    .full    (full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - directed and randomized checks of dram_arbiter against a queue-based model
`ifndef XLEN
`define XLEN 32
`endif

module tb_dram_arbiter;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        ibus_req, ibus_addr_ok, ibus_data_ok;
  logic [31:0] ibus_addr, ibus_rdata;
  logic        dbus_req, dbus_wr, dbus_addr_ok, dbus_data_ok;
  logic [1:0]  dbus_size;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_wstrb;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, arb_err;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  dram_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_b(rst_b),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_addr_ok(ibus_addr_ok),
    .ibus_data_ok(ibus_data_ok), .ibus_rdata(ibus_rdata),
    .dbus_req(dbus_req), .dbus_wr(dbus_wr), .dbus_size(dbus_size), .dbus_addr(dbus_addr),
    .dbus_wstrb(dbus_wstrb), .dbus_wdata(dbus_wdata), .dbus_addr_ok(dbus_addr_ok),
    .dbus_data_ok(dbus_data_ok), .dbus_rdata(dbus_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Requester and memory-side stimulus; a requester holds its fields until accepted
  bit          ib_pend, db_pend, db_w, m_aok, m_dok;
  logic [31:0] ib_a, db_a, db_wd, m_rd;
  logic [1:0]  db_sz;
  logic [3:0]  db_st;

  // Reference model: issue-order queue of source IDs, stall lock, sticky error
  bit q[$];
  bit lk_v, lk_s, err_m, last_g;

  bit          o_ib_aok, o_db_aok, o_ib_dok, o_db_dok, o_mreq, o_mwr;
  logic [31:0] o_maddr, o_ib_rd;

  task automatic tick();
    bit g, any, full, mreq, acc, dok_i, dok_d;
    ibus_req = ib_pend;  ibus_addr = ib_a;
    dbus_req = db_pend;  dbus_wr = db_w;  dbus_size = db_sz;  dbus_addr = db_a;
    dbus_wstrb = db_st;  dbus_wdata = db_wd;
    mem_addr_ok = m_aok; mem_data_ok = m_dok; mem_rdata = m_rd;
    #4;
    full = (q.size() == MAXO);
    if (lk_v) begin
      g   = lk_s;
      any = g ? db_pend : ib_pend;
    end else begin
      any = ib_pend | db_pend;
      if (ib_pend && db_pend) begin
`ifdef DRAM_ARB_RR_EN
        g = ~last_g;
`else
        g = 1'b1;
`endif
      end else begin
        g = db_pend;
      end
    end
    mreq  = any && !full;
    acc   = mreq && m_aok;
    dok_i = m_dok && q.size() > 0 && q[0] == 1'b0;
    dok_d = m_dok && q.size() > 0 && q[0] == 1'b1;
    chk("mem_req", mem_req, mreq);
    chk("ibus_addr_ok", ibus_addr_ok, acc && !g);
    chk("dbus_addr_ok", dbus_addr_ok, acc && g);
    chk("ibus_data_ok", ibus_data_ok, dok_i);
    chk("dbus_data_ok", dbus_data_ok, dok_d);
    chk("arb_err", arb_err, err_m);
    if (mreq) begin
      chk("mem_addr", mem_addr, g ? db_a : ib_a);
      chk("mem_wr", mem_wr, g ? db_w : 1'b0);
      chk("mem_size", mem_size, g ? db_sz : 2'd2);
      chk("mem_wstrb", mem_wstrb, g ? db_st : 4'h0);
      chk("mem_wdata", mem_wdata, g ? db_wd : 32'h0);
    end
    if (dok_i) chk("ibus_rdata", ibus_rdata, m_rd);
    if (dok_d) chk("dbus_rdata", dbus_rdata, m_rd);
    o_ib_aok = ibus_addr_ok; o_db_aok = dbus_addr_ok;
    o_ib_dok = ibus_data_ok; o_db_dok = dbus_data_ok;
    o_mreq = mem_req; o_mwr = mem_wr; o_maddr = mem_addr; o_ib_rd = ibus_rdata;
    @(posedge clk);
    if (m_dok) begin
      if (q.size() > 0) void'(q.pop_front());
      else err_m = 1'b1;
    end
    if (acc) begin
      q.push_back(g);
      last_g = g;
      if (g) db_pend = 1'b0;
      else   ib_pend = 1'b0;
    end
    lk_v = mreq && !m_aok;
    lk_s = g;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    m_aok = 1'b1;
    while ((ib_pend || db_pend || q.size() > 0) && n < 50) begin
      m_dok = (q.size() > 0);
      m_rd  = $urandom;
      tick();
      n++;
    end
    m_dok = 1'b0;
    if (n >= 50) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_b = 1'b0;
    ib_pend = 0; db_pend = 0; db_w = 0; m_aok = 1; m_dok = 0;
    ib_a = 32'h100; db_a = 0; db_wd = 0; m_rd = 0; db_sz = 0; db_st = 0;
    lk_v = 0; lk_s = 0; err_m = 0; last_g = 0;
    ibus_req = 1'b1; dbus_req = 1'b1; ibus_addr = 0; dbus_wr = 0; dbus_size = 0;
    dbus_addr = 0; dbus_wstrb = 0; dbus_wdata = 0;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_ibus_addr_ok", ibus_addr_ok, 1'b0);
    chk("rst_dbus_addr_ok", dbus_addr_ok, 1'b0);
    chk("rst_arb_err", arb_err, 1'b0);
    rst_b = 1'b1;

    // Single fetch, response two cycles after accept
    ib_pend = 1; ib_a = 32'h100; m_aok = 1;
    tick();
    chk("t1_ibus_addr_ok", o_ib_aok, 1'b1);
    m_aok = 0;
    tick();
    m_dok = 1; m_rd = 32'h0000_0013;
    tick();
    chk("t1_ibus_data_ok", o_ib_dok, 1'b1);
    chk("t1_ibus_rdata", o_ib_rd, 32'h0000_0013);
    chk("t1_dbus_data_ok", o_db_dok, 1'b0);
    m_dok = 0;

    // Simultaneous pair: dbus store wins; the follow-up pair shows round-robin
    ib_pend = 1; ib_a = 32'h104;
    db_pend = 1; db_w = 1; db_sz = 2'd2; db_a = 32'h200; db_st = 4'hF; db_wd = 32'hDEADBEEF;
    m_aok = 1;
    tick();
    chk("t2_mem_addr", o_maddr, 32'h200);
    chk("t2_mem_wr", o_mwr, 1'b1);
    db_pend = 1; db_w = 0; db_sz = 2'd0; db_a = 32'h204; db_st = 4'h0; db_wd = 32'h0;
    tick();
`ifdef DRAM_ARB_RR_EN
    chk("t2_second_pair", o_maddr, 32'h104);
`else
    chk("t2_second_pair", o_maddr, 32'h204);
`endif
    drain();

    // Stalled ibus keeps the grant while dbus arrives
    m_aok = 0; ib_pend = 1; ib_a = 32'h300;
    tick();
    db_pend = 1; db_w = 0; db_sz = 2'd1; db_a = 32'h400;
    tick();
    tick();
    chk("t3_locked_addr", o_maddr, 32'h300);
    m_aok = 1;
    tick();
    chk("t3_ibus_first", o_ib_aok, 1'b1);
    chk("t3_dbus_waits", o_db_aok, 1'b0);
    tick();
    chk("t3_dbus_next", o_db_aok, 1'b1);

    // Full: no issue, then in-order routing with a pop+push at count 1
    ib_pend = 1; ib_a = 32'h500;
    tick();
    chk("t4_full_blocks", o_mreq, 1'b0);
    m_dok = 1; m_rd = 32'h1111_0000;
    tick();
    chk("t4_first_resp_ibus", o_ib_dok, 1'b1);
    chk("t4_bubble_when_full", o_mreq, 1'b0);
    m_rd = 32'h2222_0000;
    tick();
    chk("t5_resp_dbus", o_db_dok, 1'b1);
    chk("t5_same_cycle_accept", o_ib_aok, 1'b1);
    m_rd = 32'h3333_0000;
    tick();
    chk("t5_resp_ibus", o_ib_dok, 1'b1);
    m_dok = 0;

    // Spurious response, then asynchronous reset mid-transaction
    m_dok = 1;
    tick();
    chk("t6_no_ibus_dok", o_ib_dok, 1'b0);
    chk("t6_no_dbus_dok", o_db_dok, 1'b0);
    m_dok = 0;
    tick();
    chk("t6_arb_err_sticky", arb_err, 1'b1);
    ib_pend = 1; ib_a = 32'h600; m_aok = 1;
    tick();
    ib_pend = 1; ib_a = 32'h604; m_aok = 0;
    ibus_req = 1'b1; ibus_addr = ib_a; mem_addr_ok = 1'b0;
    #2 rst_b = 1'b0;
    #1;
    chk("t6_rst_arb_err", arb_err, 1'b0);
    chk("t6_rst_mem_req", mem_req, 1'b0);
    q.delete(); err_m = 0; lk_v = 0; last_g = 0; ib_pend = 0;
    @(negedge clk);
    rst_b = 1'b1;
    m_dok = 1;
    tick();
    chk("t6_fifo_cleared", o_ib_dok, 1'b0);
    m_dok = 0;
    rst_b = 1'b0;
    q.delete(); err_m = 0; lk_v = 0; last_g = 0;
    @(negedge clk);
    rst_b = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if (!ib_pend && ($urandom % 3 == 0)) begin
        ib_pend = 1; ib_a = $urandom & 32'hFFFF_FFFC;
      end
      if (!db_pend && ($urandom % 3 == 0)) begin
        db_pend = 1; db_w = $urandom % 2; db_sz = 2'($urandom % 3);
        db_a = $urandom; db_st = 4'($urandom); db_wd = $urandom;
      end
      m_aok = ($urandom % 2);
      m_dok = (q.size() > 0) && ($urandom % 2 == 1);
      m_rd  = $urandom;
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares one unified memory bus between two requesters: the instruction-fetch port (ibus, from IF) and the data port (dbus, from the EX/MEM load/store path).
- All ports use the sram-like handshake. A request is held with req until addr_ok; responses return later, in order, on data_ok.
- The block arbitrates requests, locks the grant while a request is stalled, and tracks outstanding transactions so each data_ok/rdata is routed to the requester that issued it.

Parameters:
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions on the unified bus (>=1).
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter (derived; not overridden).

Ports:
- clk  in  1  clock
- rst_b  in  1  asynchronous active-low reset
- ibus_req  in  1  fetch request valid
- ibus_addr  in  `XLEN  fetch address
- ibus_addr_ok  out  1  fetch request accepted
- ibus_data_ok  out  1  fetch response valid
- ibus_rdata  out  `XLEN  fetch read data
- dbus_req  in  1  data request valid
- dbus_wr  in  1  1=store, 0=load
- dbus_size  in  2  0=byte, 1=half, 2=word
- dbus_addr  in  `XLEN  data address
- dbus_wstrb  in  `XLEN/8  store byte enables
- dbus_wdata  in  `XLEN  store data
- dbus_addr_ok  out  1  data request accepted
- dbus_data_ok  out  1  data response valid (loads and stores)
- dbus_rdata  out  `XLEN  load data
- mem_req  out  1  unified bus request
- mem_wr  out  1  unified write
- mem_size  out  2  unified size
- mem_addr  out  `XLEN  unified address
- mem_wstrb  out  `XLEN/8  unified byte enables
- mem_wdata  out  `XLEN  unified write data
- mem_addr_ok  in  1  unified request accepted
- mem_data_ok  in  1  unified response valid
- mem_rdata  in  `XLEN  unified read data
- arb_err  out  1  sticky protocol error

Behaviour:
- Reset: asynchronous assert on rst_b=0.
  - Cleared: lock state IDLE, outstanding count 0, ID FIFO empty, arb_err 0.
  - All req/addr_ok/data_ok outputs are 0 while reset is asserted.
  - In-flight transactions are discarded.
- full = (count == MAX_OUTSTANDING).
- State IDLE:
  - Grant selection is combinational. Default priority: dbus over ibus.
  - mem_req = (dbus_req | ibus_req) & ~full.
  - mem_* fields are muxed from the granted source.
  - ibus requests drive mem_wr=0, mem_size=2, mem_wstrb=0, mem_wdata=0.
- Transition IDLE -> LOCKED: mem_req=1 & mem_addr_ok=0. The granted source ID is registered.
- State LOCKED:
  - mem_req and the mux are driven only from the locked source.
  - The other requester is not granted, even if it has higher priority.
  - Return to IDLE when mem_addr_ok=1.
  - The requester must hold req and its fields stable; the block does not re-check them.
- Accept rule:
  - src_addr_ok = mem_req & mem_addr_ok & grant==src (zero-latency pass-through).
  - On accept, the source ID (0=ibus, 1=dbus) is pushed to the FIFO and count increments.
- Response rule:
  - On mem_data_ok, the FIFO head is popped and count decrements.
  - ibus_data_ok or dbus_data_ok = mem_data_ok & head==src, same cycle.
  - Both rdata outputs carry mem_rdata unconditionally; they are valid only with the matching data_ok.
- Simultaneous accept and response: push and pop in the same cycle; count unchanged.
- When full, no new request is issued, even if a pop occurs that cycle. This costs one bubble and keeps timing off the data_ok path.
- mem_data_ok with the FIFO empty:
  - arb_err is set (sticky until reset).
  - Both src data_ok outputs stay 0 and count stays 0.
- Latency: zero-cycle combinational path for req->mem_req and for data_ok routing. No added pipeline stage.
- Ordering: responses are strictly in order; the unified bus guarantees in-order data_ok.

Optional Feature:
- Macro: DRAM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last-grant register (reset 0 = ibus) updates on each accept.
  - When both requesters are pending in IDLE, grant goes to the source not granted last.
- Undefined: fixed priority, dbus over ibus; no last-grant register.
- Locking and tracking behaviour are identical in both builds.

Decomposition:
- Shared package entries (core.svh style defines):
  - source ID constants: SRC_IBUS=0, SRC_DBUS=1
  - size encodings: MEM_SIZE_B/H/W
  - arbiter state encoding: ARB_IDLE, ARB_LOCKED
- One sub-module: dram_arb_id_fifo.
  - Depth MAX_OUTSTANDING, 1-bit entries.
  - Provides push/pop/head/full/empty/count.
  - Pointers wrap modulo depth.

Test Plan:
- ibus_req only at addr 0x100; mem_addr_ok=1, data_ok 2 cycles later with rdata 0x00000013 -> ibus_addr_ok same cycle, ibus_data_ok=1 with 0x00000013, dbus_data_ok stays 0.
- ibus and dbus request together, dbus store 0x200 wstrb=0xF wdata 0xDEADBEEF -> mem_addr=0x200, mem_wr=1 granted first. With DRAM_ARB_RR_EN, the second simultaneous pair grants ibus.
- ibus request with mem_addr_ok held 0 for 3 cycles while dbus_req rises in cycle 1 -> mem_addr stays the ibus address until addr_ok. The ibus accept comes first; dbus is accepted the next cycle.
- Issue 2 accepts with no data_ok (MAX_OUTSTANDING=2) -> mem_req=0 while full. Two data_ok pulses route ibus then dbus in issue order.
- Accept and data_ok in the same cycle at count=1 -> count stays 1 and routing stays correct.
- mem_data_ok pulse with nothing outstanding -> arb_err=1 sticky, no src data_ok. rst_b low mid-transaction clears arb_err and count asynchronously.
